// File: rtl/seq_mult_hs.sv
// Sequential shift-add multiplier, one multiplier bit per clock, with
// start/done handshake and runtime signed/unsigned operand mode.
module seq_mult_hs #(
  parameter int M = 8,
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           signed_mode,
  input  logic [M-1:0]   D,
  input  logic [N-1:0]   Q,
  output logic           busy,
  output logic           done,
  output logic [M+N-1:0] out
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           state, state_nxt;
  logic [M+N-1:0]   acc;
  logic [M-1:0]     d_mag;
  logic             neg;
  logic [CW-1:0]    count;
  logic [M:0]       sum;

  // Most-negative operand maps to 2^(W-1), which still fits unsigned in W bits.
  function automatic logic [M-1:0] mag_d(input logic [M-1:0] v, input logic sm);
    return (sm && v[M-1]) ? -v : v;
  endfunction

  function automatic logic [N-1:0] mag_q(input logic [N-1:0] v, input logic sm);
    return (sm && v[N-1]) ? -v : v;
  endfunction

  function automatic logic [M+N-1:0] apply_sign(input logic [M+N-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  assign busy = (state != IDLE);

  always_comb begin
    sum = {1'b0, acc[M+N-1:N]} + (acc[0] ? {1'b0, d_mag} : '0);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (count == CW'(N - 1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      count <= '0;
      d_mag <= '0;
      neg   <= 1'b0;
      done  <= 1'b0;
      out   <= '0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            d_mag <= mag_d(D, signed_mode);
            acc   <= {{M{1'b0}}, mag_q(Q, signed_mode)};
            neg   <= signed_mode & (D[M-1] ^ Q[N-1]);
            count <= '0;
          end
        end
        // Carry out of the partial-sum add becomes the new top bit after the shift.
        RUN: begin
          acc   <= {sum, acc[N-1:1]};
          count <= count + 1'b1;
        end
        FIX: begin
          out  <= apply_sign(acc, neg);
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
